// File: rtl/tty_pkg.sv
// Shared TX frame constants and FSM state encoding for the TTY UART.
package tty_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int ASCII_BITS = 7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy comes from pointers carrying one extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/d_tty_uart.sv
// TTY character port: buffers 7-bit ASCII writes and serialises them as 8N1 frames.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued character
//   ST_START | start bit (low) for CLK_DIV cycles
//   ST_DATA  | 8 data bits LSB first, bit 7 forced 0
//   ST_STOP  | stop bit (high); chains straight into the next frame if queued
module d_tty_uart
    import tty_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [ASCII_BITS-1:0]  din_i,
    output logic                   txd_o,
    output logic                   full_o,
    output logic                   busy_o,
    output logic                   ovf_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int BW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DATA_BITS - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [BW-1:0]         baud_cnt;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic [ASCII_BITS-1:0] head;
    logic                  pop;
    logic                  empty;
    logic                  baud_tc;
    logic                  bit_tc;
    logic                  txd_next;
    logic                  txd_q;
    logic                  ovf_q;

    sync_fifo #(
        .WIDTH (ASCII_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (we_i),
        .pop   (pop),
        .din   (din_i),
        .dout  (head),
        .full  (full_o),
        .empty (empty),
        .level (level_o)
    );

    assign baud_tc = (baud_cnt == '0);
    assign bit_tc  = (bit_cnt == '0);
    assign busy_o  = (state != ST_IDLE) || !empty;
    assign txd_o   = txd_q;
    assign ovf_o   = ovf_q;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd_next   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                txd_next = 1'b0;
                if (baud_tc) state_next = ST_DATA;
            end
            ST_DATA: begin
                txd_next = shreg[0];
                if (baud_tc && bit_tc) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (baud_tc) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The line is driven from its own flop, one cycle behind the FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_next;
            txd_q <= txd_next;
            if (we_i && full_o) ovf_q <= 1'b1;
            if (pop) begin
                shreg    <= {{(DATA_BITS - ASCII_BITS){1'b0}}, head};
                baud_cnt <= BAUD_LOAD;
                bit_cnt  <= BIT_LOAD;
            end else if (state != ST_IDLE) begin
                baud_cnt <= baud_tc ? BAUD_LOAD : baud_cnt - BW'(1);
                if (state == ST_DATA && baud_tc) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_tc ? BIT_LOAD : bit_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_d_tty_uart.sv
// Directed bench for d_tty_uart: a line monitor decodes frames and checks them against a queue of expected characters.
module tb_d_tty_uart;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    typedef struct {
        logic [6:0] ch;
        bit         contig;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       we;
    logic [6:0] din;
    logic       txd;
    logic       full;
    logic       busy;
    logic       ovf;
    logic [2:0] level;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    int         mstate    = 0;
    int         mcnt      = 0;
    int         cyc       = 0;
    int         start_cyc = 0;
    int         end_cyc   = -100;
    logic [9:0] fr;
    exp_t       mon_e;

    d_tty_uart #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we),
        .din_i   (din),
        .txd_o   (txd),
        .full_o  (full),
        .busy_o  (busy),
        .ovf_o   (ovf),
        .level_o (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ch(input logic [6:0] ch, input bit contig);
        sb.push_back('{ch: ch, contig: contig});
    endtask

    task automatic write_char(input logic [6:0] ch);
        we  = 1'b1;
        din = ch;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && mstate == 0) begin
                done = 1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
        end
    endtask

    // Line monitor: frame bits are sampled at cycle 2 of each bit period.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mstate = 0;
        end else if (mstate == 0) begin
            if (txd === 1'b0) begin
                mstate    = 1;
                mcnt      = 1;
                start_cyc = cyc;
            end
        end else begin
            mcnt++;
            if (mcnt % CLK_DIV == 2) fr[mcnt / CLK_DIV] = txd;
            if (mcnt == FRAME) begin
                mstate = 0;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got frame 0x%0h, required none", fr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("frame_bits", {22'd0, fr}, {22'd0, 1'b1, 1'b0, mon_e.ch, 1'b0});
                    if (mon_e.contig) chk("frame_contiguous", start_cyc, end_cyc + 1);
                end
                end_cyc = cyc;
            end
        end
    end

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("release_idle", {txd, full, busy, ovf, level}, 7'b1000000);
        end

        // single character, latency and end-of-frame busy
        @(negedge clk);
        expect_ch(7'h41, 1'b0);
        write_char(7'h41);
        @(negedge clk);
        chk("single_level_e0", level, 1);
        chk("single_txd_e0", txd, 1);
        @(negedge clk);
        chk("single_txd_e1", txd, 1);
        chk("single_busy_e1", busy, 1);
        chk("single_level_e1", level, 0);
        @(negedge clk);
        chk("single_txd_fall_e2", txd, 0);
        repeat (38) @(negedge clk);
        chk("single_busy_e40", busy, 1);
        @(negedge clk);
        chk("single_busy_e41", busy, 0);
        chk("single_txd_e41", txd, 1);
        wait_idle(20);

        // back-to-back frames
        @(negedge clk);
        expect_ch(7'h55, 1'b0);
        write_char(7'h55);
        expect_ch(7'h2A, 1'b1);
        write_char(7'h2A);
        expect_ch(7'h7F, 1'b1);
        write_char(7'h7F);
        wait_idle(200);

        // overflow
        @(negedge clk);
        expect_ch(7'h00, 1'b0);
        write_char(7'h00);
        @(posedge clk);
        #1;
        for (int c = 'h31; c <= 'h34; c++) begin
            expect_ch(7'(c), 1'b1);
            write_char(7'(c));
        end
        @(negedge clk);
        chk("ovf_full_at4", full, 1);
        chk("ovf_flag_before", ovf, 0);
        chk("ovf_level_at4", level, 4);
        write_char(7'h35);
        @(negedge clk);
        chk("ovf_full_after", full, 1);
        chk("ovf_flag_after", ovf, 1);
        chk("ovf_level_after", level, 4);
        wait_idle(300);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_full_drained", full, 0);

        // reset mid-frame, with a write in the reset cycle
        @(negedge clk);
        write_char(7'h41);
        write_char(7'h42);
        write_char(7'h43);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("rst_level_before", level, 2);
        chk("rst_busy_before", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        we  = 1'b1;
        din = 7'h44;
        @(posedge clk);
        #1;
        rst = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_full", full, 0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("rst_quiet", {txd, busy, level}, 5'b10000);
        end

        // push/pop collision on the STOP-to-START edge
        @(negedge clk);
        expect_ch(7'h61, 1'b0);
        write_char(7'h61);
        expect_ch(7'h62, 1'b1);
        write_char(7'h62);
        expect_ch(7'h63, 1'b1);
        write_char(7'h63);
        repeat (38) @(posedge clk);
        @(negedge clk);
        chk("coll_level_before", level, 2);
        expect_ch(7'h20, 1'b1);
        write_char(7'h20);
        @(negedge clk);
        chk("coll_level_after", level, 2);
        wait_idle(250);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/d_tty_uart.md
D_TTY_UART -- requirements
Module: d_tty_uart

Interface
REQ-001 Parameter CLK_DIV, default 16: clock cycles per UART bit, legal range 2..65535.
REQ-002 Parameter DEPTH, default 8: character FIFO depth, power of two, legal range 2..64.
REQ-003 clk_i  input  1  single clock; all logic rises on posedge clk_i.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 we_i  input  1  character write strobe from the bus TTY decode, sampled each posedge.
REQ-006 din_i  input  7  7-bit ASCII character, qualified by we_i.
REQ-007 txd_o  output  1  UART serial line, 8N1, idle high.
REQ-008 full_o  output  1  FIFO holds DEPTH entries.
REQ-009 busy_o  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-010 ovf_o  output  1  sticky flag: a write was dropped.
REQ-011 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 A write with we_i=1 and full_o=0 shall store din_i at the FIFO tail; level_o shall increment on the following edge.
REQ-013 A write with we_i=1 and full_o=1 shall be discarded, with FIFO contents unchanged and ovf_o set to 1 until reset, including when a pop occurs in the same cycle.
REQ-014 full_o and level_o shall be registered and reflect the state after the last edge.
REQ-015 The TX FSM shall have the states IDLE, START, DATA and STOP.
REQ-016 IDLE: txd_o=1; when level_o>0 the FSM shall pop the head into the shift register and enter START on the same edge.
REQ-017 START: txd_o=0 for CLK_DIV cycles, then DATA.
REQ-018 DATA: 8 bits, LSB first, each held CLK_DIV cycles; bits 0..6 = character, bit 7 = 0; then STOP.
REQ-019 STOP: txd_o=1 for CLK_DIV cycles; then, if level_o>0, pop and enter START directly with no idle gap, else enter IDLE.
REQ-020 Latency: with the block idle and the FIFO empty, txd_o shall fall on the 2nd posedge after the edge that samples we_i.
REQ-021 A simultaneous write and pop with 0<level_o<DEPTH shall leave level_o unchanged; a pop is never issued while the FIFO is empty.
REQ-022 The bit counter and baud counter shall wrap only under FSM control; no partial bit period shall be emitted.
REQ-023 FIFO pointers shall wrap modulo DEPTH; occupancy shall be tracked with an extra pointer bit.
REQ-024 busy_o shall be 0 exactly when the FSM is in IDLE and level_o=0.

Reset
REQ-025 On the edge where rst_i=1 is sampled, reset shall force txd_o=1, full_o=0, busy_o=0, ovf_o=0, level_o=0, FSM=IDLE, and clear all counters and pointers.
REQ-026 Reset mid-frame shall abort the frame immediately; txd_o=1 from the next cycle, and the FIFO contents shall be lost.
REQ-027 A write asserted in the same cycle as rst_i shall be ignored.

Structure
REQ-028 FSM state encodings and the frame constants (DATA_BITS=8, ASCII_BITS=7) shall live in the shared package tty_pkg.
REQ-029 The FIFO shall be a separate sub-module, sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/level ports.
REQ-030 d_tty_uart shall contain only the FSM, the baud counter, the bit counter, the shift register and the overflow flag.

Verification (CLK_DIV=4, DEPTH=4)
REQ-031 Single character: write 0x41 when idle -> txd_o falls at edge +2; 40-cycle frame bits 0,1,0,0,0,0,0,1,0,1; then busy_o=0.
REQ-032 Back-to-back: write 0x55, 0x2A, 0x7F on consecutive cycles -> 3 contiguous frames (120 cycles) with no idle bit between them; the 0x7F frame is 0,1,1,1,1,1,1,1,0,1.
REQ-033 Overflow: write 0x00; once START is entered, write 0x31..0x35 on consecutive cycles -> 0x31..0x34 accepted, 0x35 dropped, full_o=1, ovf_o=1; 5 frames are sent in total.
REQ-034 Reset mid-frame: assert rst_i during data bit 3 of 0x41 with 2 characters queued -> next cycle txd_o=1, level_o=0, busy_o=0, ovf_o=0; no further frames.
REQ-035 Pop/push collision: with level_o=2 and a STOP-to-START pop edge, write 0x20 on that edge -> level_o stays 2 and the character order is preserved.
REQ-036 A reset-release check shall confirm txd_o=1 and all flags 0 for 100 idle cycles with we_i=0.
